// File: rtl/adma_pkg.sv
// Shared definitions for the ADMA data mover AXI issuers: burst/response
// encodings, default channel-id type and the ARSIZE/AWSIZE helper.
package adma_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int DMA_CHN_NUM_DEF = 4;
  typedef logic [$clog2(DMA_CHN_NUM_DEF)-1:0] chn_id_t;

  // Beat size code for a data bus of data_w bits (8 -> 0, 16 -> 1, ... 1024 -> 7).
  function automatic logic [2:0] arsize_f(input int data_w);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((8 << i) == data_w) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/adma_dm_axi_ar_if.sv
// AR-channel bundle of the data mover: the AXI AR master signals plus the
// {chn_id, arid, arlen} record handed to the R stage.
interface adma_dm_axi_ar_if #(
  parameter int DMA_CHN_NUM_W = 2,
  parameter int MST_ID_W      = 5,
  parameter int SRC_ADDR_W    = 32,
  parameter int ATX_LEN_W     = 8,
  parameter int ATX_SIZE_W    = 3
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; once valid rises, it and its payload hold until that transfer.
  logic [MST_ID_W-1:0]      m_arid_o;
  logic [SRC_ADDR_W-1:0]    m_araddr_o;
  logic [ATX_LEN_W-1:0]     m_arlen_o;
  logic [ATX_SIZE_W-1:0]    m_arsize_o;
  logic [1:0]               m_arburst_o;
  logic                     m_arvalid_o;
  logic                     m_arready_i;

  logic [DMA_CHN_NUM_W-1:0] atx_chn_id;
  logic [MST_ID_W-1:0]      atx_arid;
  logic [ATX_LEN_W-1:0]     atx_arlen;
  logic                     atx_vld;
  logic                     atx_rdy;

  modport mst (
    output m_arid_o, m_araddr_o, m_arlen_o, m_arsize_o, m_arburst_o, m_arvalid_o,
    input  m_arready_i,
    output atx_chn_id, atx_arid, atx_arlen, atx_vld,
    input  atx_rdy
  );

  modport slv (
    input  m_arid_o, m_araddr_o, m_arlen_o, m_arsize_o, m_arburst_o, m_arvalid_o,
    output m_arready_i,
    input  atx_chn_id, atx_arid, atx_arlen, atx_vld,
    output atx_rdy
  );

endinterface

// File: rtl/adma_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer and
// moves the pointer just past the winner when the grant is taken (adv).
module adma_rr_arb #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!gnt_vld && req[cand]) begin
        gnt_vld      = 1'b1;
        gnt_idx      = cand;
        gnt_oh[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv && gnt_vld) begin
      ptr_d = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/adma_dm_axi_ar.sv
// AXI AR issuer of the DMA data mover: arbitrates per-channel read requests
// into one issue slot that drives both the AR channel and the R-stage record.
module adma_dm_axi_ar
  import adma_pkg::*;
#(
  parameter  int DMA_CHN_NUM    = 4,
  parameter  int MST_ID_W       = 5,
  parameter  int SRC_ADDR_W     = 32,
  parameter  int ATX_LEN_W      = 8,
  parameter  int ATX_SIZE_W     = 3,
  parameter  int ATX_SRC_DATA_W = 256,
  localparam int DMA_CHN_NUM_W  = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DMA_CHN_NUM*SRC_ADDR_W-1:0] req_addr,
  input  logic [DMA_CHN_NUM*ATX_LEN_W-1:0]  req_len,
  input  logic [DMA_CHN_NUM-1:0]            req_vld,
  output logic [DMA_CHN_NUM-1:0]            req_rdy,
  input  logic [DMA_CHN_NUM*MST_ID_W-1:0]   atx_id,
  adma_dm_axi_ar_if.mst                     bus
);

  localparam logic [ATX_SIZE_W-1:0] ARSIZE = ATX_SIZE_W'(arsize_f(ATX_SRC_DATA_W));
  localparam int BEAT_BYTES = ATX_SRC_DATA_W / 8;

  logic [DMA_CHN_NUM_W-1:0] chn_q, chn_d;
  logic [MST_ID_W-1:0]      id_q, id_d;
  logic [SRC_ADDR_W-1:0]    addr_q, addr_d;
  logic [ATX_LEN_W-1:0]     len_q, len_d;
  logic                     ar_pend_q, ar_pend_d;
  logic                     atx_pend_q, atx_pend_d;

  logic [DMA_CHN_NUM-1:0]   gnt_oh;
  logic [DMA_CHN_NUM_W-1:0] gnt_idx;
  logic                     gnt_vld;
  logic                     ar_pend_nx, atx_pend_nx;
  logic                     slot_free, grant;
  logic [MST_ID_W-1:0]      sel_id;
  logic [SRC_ADDR_W-1:0]    sel_addr;
  logic [ATX_LEN_W-1:0]     sel_len;

  adma_rr_arb #(.N(DMA_CHN_NUM)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_vld),
    .adv     (grant),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // The slot counts as free already in the cycle its last pending handshake
  // completes, which gives back-to-back bursts when both readys stay high.
  always_comb begin
    ar_pend_nx  = ar_pend_q & ~bus.m_arready_i;
    atx_pend_nx = atx_pend_q & ~bus.atx_rdy;
    slot_free   = rst_n & ~ar_pend_nx & ~atx_pend_nx;
    grant       = slot_free & gnt_vld;
    req_rdy     = grant ? gnt_oh : '0;
  end

  always_comb begin
    sel_id   = '0;
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      if (gnt_oh[i]) begin
        sel_id   = atx_id[i*MST_ID_W +: MST_ID_W];
        sel_addr = req_addr[i*SRC_ADDR_W +: SRC_ADDR_W];
        sel_len  = req_len[i*ATX_LEN_W +: ATX_LEN_W];
      end
    end
  end

  always_comb begin
    ar_pend_d  = ar_pend_nx | grant;
    atx_pend_d = atx_pend_nx | grant;
    chn_d      = chn_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    if (grant) begin
      chn_d  = gnt_idx;
      id_d   = sel_id;
      addr_d = sel_addr;
      len_d  = sel_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chn_q      <= '0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      ar_pend_q  <= 1'b0;
      atx_pend_q <= 1'b0;
    end else begin
      chn_q      <= chn_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      ar_pend_q  <= ar_pend_d;
      atx_pend_q <= atx_pend_d;
    end
  end

  assign bus.m_arid_o    = id_q;
  assign bus.m_araddr_o  = addr_q;
  assign bus.m_arlen_o   = len_q;
  assign bus.m_arsize_o  = ARSIZE;
  assign bus.m_arburst_o = AXI_BURST_INCR;
  assign bus.m_arvalid_o = ar_pend_q;
  assign bus.atx_chn_id  = chn_q;
  assign bus.atx_arid    = id_q;
  assign bus.atx_arlen   = len_q;
  assign bus.atx_vld     = atx_pend_q;

`ifndef SYNTHESIS
  // Upstream splits bursts at 4KB boundaries; catch any request that does not.
  logic [SRC_ADDR_W-1:0] burst_last;
  always_comb begin
    burst_last = sel_addr + SRC_ADDR_W'((32'(sel_len) + 32'd1) * 32'(BEAT_BYTES) - 32'd1);
  end

  a_no_4k_cross: assert property (@(posedge clk) disable iff (!rst_n)
    grant |-> (sel_addr[SRC_ADDR_W-1:12] == burst_last[SRC_ADDR_W-1:12]));
`endif

endmodule

// File: tb/tb_adma_dm_axi_ar.sv
// Bench for adma_dm_axi_ar: directed scenarios then random traffic, all checked
// cycle by cycle against a behavioural issue-slot model.
module tb_adma_dm_axi_ar;
  import adma_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 5;
  localparam int AW  = 32;
  localparam int LW  = 8;
  localparam int DW  = 256;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*AW-1:0]   req_addr;
  logic [N*LW-1:0]   req_len;
  logic [N-1:0]      req_vld;
  logic [N-1:0]      req_rdy;
  logic [N*IDW-1:0]  atx_id;

  adma_dm_axi_ar_if #(
    .DMA_CHN_NUM_W(CW), .MST_ID_W(IDW), .SRC_ADDR_W(AW), .ATX_LEN_W(LW), .ATX_SIZE_W(3)
  ) bus ();

  adma_dm_axi_ar #(
    .DMA_CHN_NUM(N), .MST_ID_W(IDW), .SRC_ADDR_W(AW), .ATX_LEN_W(LW),
    .ATX_SIZE_W(3), .ATX_SRC_DATA_W(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_addr (req_addr),
    .req_len  (req_len),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .atx_id   (atx_id),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // per-channel request payloads
  logic [AW-1:0]  pl_addr[N];
  logic [LW-1:0]  pl_len[N];
  logic [IDW-1:0] pl_id[N];

  // behavioural model: one outstanding burst, split into AR part and record part
  int             m_ptr;
  bit             m_ar, m_atx;
  int             m_chn;
  logic [IDW-1:0] m_id;
  logic [AW-1:0]  m_addr;
  logic [LW-1:0]  m_len;
  int             exp_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_payloads();
    for (int c = 0; c < N; c++) begin
      req_addr[c*AW +: AW]  = pl_addr[c];
      req_len[c*LW +: LW]   = pl_len[c];
      atx_id[c*IDW +: IDW]  = pl_id[c];
    end
  endtask

  // random payloads that never cross a 4KB page
  task automatic new_payloads();
    int beats;
    for (int c = 0; c < N; c++) begin
      pl_len[c]  = LW'($urandom_range(0, 15));
      beats      = int'(pl_len[c]) + 1;
      pl_id[c]   = IDW'($urandom);
      pl_addr[c] = AW'($urandom_range(0, 255) * 4096 + 32 * $urandom_range(0, 128 - beats));
    end
    drive_payloads();
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_ar  = 1'b0;
    m_atx = 1'b0;
  endtask

  // One clock: apply inputs, check against the model, then advance the model.
  // want: -2 no directed expectation, -1 no grant, else granted channel.
  task automatic run_cycle(input logic [N-1:0] vld, input bit arr, input bit atr, input int want);
    logic [N-1:0] exp_oh;
    logic [N-1:0] want_oh;
    int c;
    req_vld         = vld;
    bus.m_arready_i = arr;
    bus.atx_rdy     = atr;
    #1;
    exp_g = -1;
    if ((!m_ar || arr) && (!m_atx || atr)) begin
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (exp_g < 0 && vld[c]) exp_g = c;
      end
    end
    exp_oh = '0;
    if (exp_g >= 0) exp_oh[exp_g] = 1'b1;
    chk("req_rdy", 64'(req_rdy), 64'(exp_oh));
    if (want != -2) begin
      want_oh = '0;
      if (want >= 0) want_oh[want] = 1'b1;
      chk("directed_grant", 64'(req_rdy), 64'(want_oh));
    end
    chk("arvalid", 64'(bus.m_arvalid_o), 64'(m_ar));
    chk("atx_vld", 64'(bus.atx_vld), 64'(m_atx));
    if (m_ar) begin
      chk("araddr", 64'(bus.m_araddr_o), 64'(m_addr));
      chk("arid", 64'(bus.m_arid_o), 64'(m_id));
      chk("arlen", 64'(bus.m_arlen_o), 64'(m_len));
      chk("arsize", 64'(bus.m_arsize_o), 64'd5);
      chk("arburst", 64'(bus.m_arburst_o), 64'd1);
    end
    if (m_atx) begin
      chk("atx_chn", 64'(bus.atx_chn_id), 64'(m_chn));
      chk("atx_arid", 64'(bus.atx_arid), 64'(m_id));
      chk("atx_arlen", 64'(bus.atx_arlen), 64'(m_len));
    end
    @(posedge clk);
    if (arr) m_ar = 1'b0;
    if (atr) m_atx = 1'b0;
    if (exp_g >= 0) begin
      m_ar   = 1'b1;
      m_atx  = 1'b1;
      m_chn  = exp_g;
      m_id   = pl_id[exp_g];
      m_addr = pl_addr[exp_g];
      m_len  = pl_len[exp_g];
      m_ptr  = (exp_g + 1) % N;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n           = 1'b0;
    req_vld         = '0;
    bus.m_arready_i = 1'b0;
    bus.atx_rdy     = 1'b0;
    new_payloads();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_arvalid", 64'(bus.m_arvalid_o), 64'd0);
    chk("rst_atx_vld", 64'(bus.atx_vld), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single request on ch2
    pl_addr[2] = 32'h0000_1000;
    pl_len[2]  = 8'd7;
    drive_payloads();
    run_cycle(4'b0100, 1'b1, 1'b1, 2);
    chk("ch2_araddr", 64'(bus.m_araddr_o), 64'h1000);
    chk("ch2_arlen", 64'(bus.m_arlen_o), 64'd7);
    chk("ch2_arid", 64'(bus.m_arid_o), 64'(pl_id[2]));
    chk("ch2_arsize", 64'(bus.m_arsize_o), 64'd5);
    chk("ch2_atx_chn", 64'(bus.atx_chn_id), 64'd2);
    chk("ch2_both_vld", 64'({bus.m_arvalid_o, bus.atx_vld}), 64'b11);
    run_cycle(4'b0000, 1'b1, 1'b1, -1);

    // all channels requesting from a fresh pointer: 0,1,2,3,0 back to back
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    new_payloads();
    for (int k = 0; k < 5; k++) run_cycle(4'b1111, 1'b1, 1'b1, k % 4);
    run_cycle(4'b0000, 1'b1, 1'b1, -1);

    // ARREADY held low: record drains first, next grant waits for ARREADY
    new_payloads();
    run_cycle(4'b0001, 1'b1, 1'b1, -2);
    for (int k = 0; k < 3; k++) run_cycle(4'b0010, 1'b0, 1'b1, -1);
    run_cycle(4'b0010, 1'b1, 1'b1, 1);
    run_cycle(4'b0000, 1'b1, 1'b1, -1);

    // atx_rdy held low: AR completes, record and further grants stall
    new_payloads();
    run_cycle(4'b1000, 1'b1, 1'b1, -2);
    for (int k = 0; k < 5; k++) run_cycle(4'b0110, 1'b1, 1'b0, -1);
    run_cycle(4'b0110, 1'b1, 1'b1, -2);
    run_cycle(4'b0000, 1'b1, 1'b1, -2);

    // pointer wrap: grant ch2 leaves ptr=3, then 0101 gives ch0 then ch2
    new_payloads();
    run_cycle(4'b0100, 1'b1, 1'b1, 2);
    run_cycle(4'b0101, 1'b1, 1'b1, 0);
    run_cycle(4'b0101, 1'b1, 1'b1, 2);
    run_cycle(4'b0000, 1'b1, 1'b1, -1);

    // reset while an AR is pending
    new_payloads();
    run_cycle(4'b0010, 1'b0, 1'b1, -2);
    run_cycle(4'b0000, 1'b0, 1'b1, -1);
    req_vld = 4'b0010;
    rst_n   = 1'b0;
    #1;
    chk("midrst_arvalid", 64'(bus.m_arvalid_o), 64'd0);
    chk("midrst_atx_vld", 64'(bus.atx_vld), 64'd0);
    chk("midrst_req_rdy", 64'(req_rdy), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle(4'b1111, 1'b1, 1'b1, 0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      new_payloads();
      run_cycle(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0), -2);
    end
    run_cycle(4'b0000, 1'b1, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
